// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame checker.
// Holds the FSM state encoding used by parity_frame_checker.
package parity_pkg;

  // ACC: accepting words of a frame; DONE: holding a frame result.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage : parity_pkg

// File: rtl/nand_xor2.sv
// Two-input XOR gate built from four two-input NAND gates.
// Ports:
//   a, b : operands
//   y    : a ^ b
module nand_xor2 (
  input  logic a,
  input  logic b,
  output logic y
);

  logic n1_s;
  logic n2_s;
  logic n3_s;

  assign n1_s = ~(a & b);
  assign n2_s = ~(a & n1_s);
  assign n3_s = ~(b & n1_s);
  assign y    = ~(n2_s & n3_s);

endmodule : nand_xor2

// File: rtl/parity_frame_checker.sv
// Accumulates the parity of every word of a valid/ready frame and, one
// cycle after the last word, presents the frame parity, a mismatch flag
// against the expected parity sampled with the last word, the saturated
// word count and an overflow flag. The result is held until handed off.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input word handshake
//   in_data, in_last      : data word, end-of-frame marker
//   in_chk                : expected frame parity (with last word only)
//   out_valid/out_ready   : result handshake
//   out_parity, out_err   : frame parity, parity mismatch
//   out_len, out_ovf      : saturated word count, count overflow
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int ODD     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  input  logic                         in_chk,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_parity,
  output logic                         out_err,
  output logic [$clog2(MAX_LEN+1)-1:0] out_len,
  output logic                         out_ovf
);

  localparam int              CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_LEN);
  localparam logic            ODD_BIT = 1'(ODD);

  state_e          state_q, state_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            par_q, par_d;
  logic            err_q, err_d;
  logic [CW-1:0]   len_q, len_d;
  logic            rovf_q, rovf_d;
  logic            in_ready_q;
  logic            out_valid_q;

  logic            red_s;
  logic            xfer_s;
  logic            hand_s;
  logic            acc_nxt_s;
  logic            cnt_sat_s;
  logic [CW-1:0]   cnt_inc_s;
  logic            ovf_nxt_s;
  logic            par_nxt_s;

  // XOR-reduction of in_data as a ripple chain of WIDTH-1 NAND-built XORs;
  // each stage keeps its own output net so the chain is not one looped vector.
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    logic y_s;
    if (i == 1) begin : g_first
      nand_xor2 u_xor (.a(in_data[0]), .b(in_data[i]), .y(y_s));
    end else begin : g_next
      nand_xor2 u_xor (.a(g_chain[i-1].y_s), .b(in_data[i]), .y(y_s));
    end
  end

  assign red_s = g_chain[WIDTH-1].y_s;

  assign xfer_s    = in_valid & in_ready_q;
  assign hand_s    = out_valid_q & out_ready;
  assign acc_nxt_s = acc_q ^ red_s;
  assign cnt_sat_s = (cnt_q == MAX_CNT);
  assign cnt_inc_s = cnt_sat_s ? cnt_q : (cnt_q + CW'(1));
  assign ovf_nxt_s = ovf_q | cnt_sat_s;
  assign par_nxt_s = acc_nxt_s ^ ODD_BIT;

  // Next-state and result capture; everything holds unless a transfer or handoff occurs.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    par_d   = par_q;
    err_d   = err_q;
    len_d   = len_q;
    rovf_d  = rovf_q;
    case (state_q)
      ST_ACC: begin
        if (xfer_s && in_last) begin
          // Capture the result and clear accumulators now; they stay clear
          // through DONE, so ACC resumes cleanly after the handoff.
          state_d = ST_DONE;
          par_d   = par_nxt_s;
          err_d   = par_nxt_s ^ in_chk;
          len_d   = cnt_inc_s;
          rovf_d  = ovf_nxt_s;
          acc_d   = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (xfer_s) begin
          acc_d = acc_nxt_s;
          cnt_d = cnt_inc_s;
          ovf_d = ovf_nxt_s;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        if (hand_s) begin
          state_d = ST_ACC;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State, accumulator and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      par_q       <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      rovf_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      par_q       <= par_d;
      err_q       <= err_d;
      len_q       <= len_d;
      rovf_q      <= rovf_d;
      in_ready_q  <= (state_d == ST_ACC);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_parity = par_q;
  assign out_err    = err_q;
  assign out_len    = len_q;
  assign out_ovf    = rovf_q;

endmodule : parity_frame_checker

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (WIDTH=8, MAX_LEN=4) with an
// even-parity instance and an odd-parity instance on a shared clock/reset.
module tb_parity_frame_checker;

  logic       clk;
  logic       rst;

  logic       in_valid, in_ready, in_last, in_chk;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_parity, out_err, out_ovf;
  logic [2:0] out_len;

  logic       o_in_valid, o_in_ready, o_in_last, o_in_chk;
  logic [7:0] o_in_data;
  logic       o_out_valid, o_out_ready, o_out_parity, o_out_err, o_out_ovf;
  logic [2:0] o_out_len;

  int n_vec;
  int n_err;

  parity_frame_checker #(.WIDTH(8), .MAX_LEN(4), .ODD(0)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_chk(in_chk),
    .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
    .out_err(out_err), .out_len(out_len), .out_ovf(out_ovf)
  );

  parity_frame_checker #(.WIDTH(8), .MAX_LEN(4), .ODD(1)) u_dut_odd (
    .clk(clk), .rst(rst),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data),
    .in_last(o_in_last), .in_chk(o_in_chk),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_parity(o_out_parity),
    .out_err(o_out_err), .out_len(o_out_len), .out_ovf(o_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic last, input logic chk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_chk   = chk;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_chk   = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic p, input logic e,
                             input logic [2:0] l, input logic o);
    check_val({tag, ".valid"},  32'(out_valid),  32'd1);
    check_val({tag, ".ready"},  32'(in_ready),   32'd0);
    check_val({tag, ".parity"}, 32'(out_parity), 32'(p));
    check_val({tag, ".err"},    32'(out_err),    32'(e));
    check_val({tag, ".len"},    32'(out_len),    32'(l));
    check_val({tag, ".ovf"},    32'(out_ovf),    32'(o));
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, ".hand_ready"}, 32'(in_ready),  32'd1);
    check_val({tag, ".hand_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1; in_chk = 1'b0; out_ready = 1'b0;
    o_in_valid = 1'b0; o_in_data = 8'h00; o_in_last = 1'b0; o_in_chk = 1'b0; o_out_ready = 1'b0;

    // Reset held two cycles with a valid last word on the input.
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
    check_val("rst.ready",  32'(in_ready),   32'd1);
    check_val("rst.valid",  32'(out_valid),  32'd0);
    check_val("rst.parity", 32'(out_parity), 32'd0);
    check_val("rst.err",    32'(out_err),    32'd0);
    check_val("rst.len",    32'(out_len),    32'd0);
    check_val("rst.ovf",    32'(out_ovf),    32'd0);
    tick();
    check_val("rst.idle_valid", 32'(out_valid), 32'd0);

    // Single word 0xA5: four ones -> even parity 0.
    send_word(8'hA5, 1'b1, 1'b0);
    check_frame("single", 1'b0, 1'b0, 3'd1, 1'b0);
    handoff("single");

    // 0x01,0x03,0x07: six ones -> parity 0, chk=1 -> err.
    send_word(8'h01, 1'b0, 1'b0);
    send_word(8'h03, 1'b0, 1'b0);
    send_word(8'h07, 1'b1, 1'b1);
    check_frame("err", 1'b0, 1'b1, 3'd3, 1'b0);

    // Backpressure: words driven while DONE must be ignored.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h01 << i;
      in_last  = (i == 2);
      in_chk   = 1'b0;
      tick();
      check_frame("bp", 1'b0, 1'b1, 3'd3, 1'b0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    handoff("bp");

    // Exactly MAX_LEN words: no overflow.
    for (int i = 0; i < 3; i++) send_word(8'h01, 1'b0, 1'b0);
    send_word(8'h01, 1'b1, 1'b0);
    check_frame("full", 1'b0, 1'b0, 3'd4, 1'b0);
    handoff("full");

    // Six words 0x01: len saturates at 4, ovf set.
    for (int i = 0; i < 5; i++) send_word(8'h01, 1'b0, 1'b0);
    send_word(8'h01, 1'b1, 1'b0);
    check_frame("ovf", 1'b0, 1'b0, 3'd4, 1'b1);
    handoff("ovf");
    send_word(8'h03, 1'b1, 1'b0);
    check_frame("post_ovf", 1'b0, 1'b0, 3'd1, 1'b0);
    handoff("post_ovf");

    // Idle gaps inside a frame: 0x01, gap, 0x03 -> three ones -> parity 1, chk 0 -> err.
    send_word(8'h01, 1'b0, 1'b0);
    tick();
    tick();
    check_val("gap.valid", 32'(out_valid), 32'd0);
    send_word(8'h03, 1'b1, 1'b0);
    check_frame("gap", 1'b1, 1'b1, 3'd2, 1'b0);
    handoff("gap");

    // Mid-frame reset discards 0xFF,0x01; then 0x80 alone -> parity 1.
    send_word(8'hFF, 1'b0, 1'b0);
    send_word(8'h01, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst.valid", 32'(out_valid), 32'd0);
    check_val("midrst.ready", 32'(in_ready),  32'd1);
    send_word(8'h80, 1'b1, 1'b0);
    check_frame("midrst", 1'b1, 1'b1, 3'd1, 1'b0);

    // Reset while DONE drops the pending result.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("donerst.valid", 32'(out_valid), 32'd0);
    check_val("donerst.len",   32'(out_len),   32'd0);

    // Odd-parity instance: 0x00 -> parity 1, chk 1 -> no error.
    o_in_valid = 1'b1; o_in_data = 8'h00; o_in_last = 1'b1; o_in_chk = 1'b1;
    tick();
    o_in_valid = 1'b0; o_in_last = 1'b0; o_in_chk = 1'b0;
    check_val("odd.valid",  32'(o_out_valid),  32'd1);
    check_val("odd.parity", 32'(o_out_parity), 32'd1);
    check_val("odd.err",    32'(o_out_err),    32'd0);
    check_val("odd.len",    32'(o_out_len),    32'd1);
    o_out_ready = 1'b1;
    tick();
    o_out_ready = 1'b0;
    check_val("odd.hand_ready", 32'(o_in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_parity_frame_checker
